// File: rtl/rom_loader_if.sv
// rom_loader_if: byte stream valid/ready handshake feeding the ROM loader
interface rom_loader_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/rom_loader.sv
// rom_loader: assembles a checksummed byte stream into ROM words and holds the CPU in reset until a good load
module rom_loader #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    rom_loader_if.slave           strm,
    output logic                  o_rom_we,
    output logic [ADDR_WIDTH-1:0] o_rom_addr,
    output logic [31:0]           o_rom_wdata,
    output logic                  o_cpu_rst,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_error,
    output logic [ADDR_WIDTH:0]   o_words_loaded
);
    typedef enum logic [2:0] {S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
    state_t                r_state;
    state_t                w_next;
    logic [15:0]           r_len;
    logic [1:0]            r_lane;
    logic [ADDR_WIDTH:0]   r_word;
    logic [7:0]            r_xor;
    logic [23:0]           r_asm;
    logic                  r_rom_we;
    logic [ADDR_WIDTH-1:0] r_rom_addr;
    logic [31:0]           r_rom_wdata;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_start_ok;
    logic                  w_big;
    logic                  w_last;
    logic [15:0]           w_len;

    assign w_len       = {strm.in_data, r_len[7:0]};
    assign w_xfer      = strm.in_valid && w_ready;
    assign w_start_ok  = i_start && (r_state inside {S_IDLE, S_DONE, S_ERR});
    assign w_big       = 32'(w_len) > (32'd1 << ADDR_WIDTH);
    assign w_last      = r_lane == 2'd3 && 32'(r_word) + 32'd1 == 32'(r_len);
    assign strm.in_ready   = w_ready;
    assign o_rom_we        = r_rom_we;
    assign o_rom_addr      = r_rom_addr;
    assign o_rom_wdata     = r_rom_wdata;
    assign o_words_loaded  = r_word;

    // state register
    always_ff @(posedge clk) begin
        r_state <= rst ? S_IDLE : w_next;
    end

    // next-state: each byte-consuming state advances only on a transfer
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_LEN0 : r_state;
            S_LEN0: w_next = w_xfer ? S_LEN1 : r_state;
            S_LEN1: w_next = !w_xfer ? r_state : w_big ? S_ERR : (w_len == 16'd0 ? S_CSUM : S_DATA);
            S_DATA: w_next = (w_xfer && w_last) ? S_CSUM : r_state;
            S_CSUM: w_next = !w_xfer ? r_state : (strm.in_data == r_xor ? S_DONE : S_ERR);
            default: w_next = S_IDLE;
        endcase
    end

    // status outputs decoded from state alone
    always_comb begin
        w_ready   = r_state inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
        o_busy    = w_ready;
        o_done    = r_state == S_DONE;
        o_error   = r_state == S_ERR;
        o_cpu_rst = r_state != S_DONE;
    end

    // datapath: length capture, byte assembly, checksum and one-cycle ROM write
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len       <= '0;
            r_lane      <= '0;
            r_word      <= '0;
            r_xor       <= '0;
            r_asm       <= '0;
            r_rom_we    <= 1'b0;
            r_rom_addr  <= '0;
            r_rom_wdata <= '0;
        end else begin
            r_rom_we <= 1'b0;
            if (w_start_ok) begin
                r_lane <= '0;
                r_word <= '0;
                r_xor  <= '0;
            end
            if (w_xfer && r_state == S_LEN0) r_len[7:0] <= strm.in_data;
            if (w_xfer && r_state == S_LEN1) r_len[15:8] <= strm.in_data;
            if (w_xfer && r_state == S_DATA) begin
                r_xor  <= r_xor ^ strm.in_data;
                r_lane <= r_lane + 2'd1;
                r_asm  <= {strm.in_data, r_asm[23:8]};
                if (r_lane == 2'd3) begin
                    r_rom_we    <= 1'b1;
                    r_rom_addr  <= r_word[ADDR_WIDTH-1:0];
                    r_rom_wdata <= {strm.in_data, r_asm};
                    r_word      <= r_word + (ADDR_WIDTH+1)'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_rom_loader.sv
// tb_rom_loader: directed and randomized frames checked against a frame-level model of the loader
module tb_rom_loader;
    localparam int AW = 8;
    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          rom_we;
    logic [AW-1:0] rom_addr;
    logic [31:0]   rom_wdata;
    logic          cpu_rst;
    logic          busy;
    logic          done;
    logic          err;
    logic [AW:0]   wl;
    int            checks = 0;
    int            failures = 0;
    logic [AW+31:0] wq[$];
    logic [31:0]    pw[$];

    rom_loader_if strm();

    rom_loader #(.ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .i_start(start), .strm(strm),
        .o_rom_we(rom_we), .o_rom_addr(rom_addr), .o_rom_wdata(rom_wdata),
        .o_cpu_rst(cpu_rst), .o_busy(busy), .o_done(done), .o_error(err),
        .o_words_loaded(wl)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rom_we) wq.push_back({rom_addr, rom_wdata});

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_in_ready"}, strm.in_ready, 0);
        chk({tag, "_rom_we"}, rom_we, 0);
        chk({tag, "_rom_addr"}, rom_addr, 0);
        chk({tag, "_rom_wdata"}, rom_wdata, 0);
        chk({tag, "_cpu_rst"}, cpu_rst, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, err, 0);
        chk({tag, "_words"}, wl, 0);
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input int maxgap, input bit st);
        int n;
        repeat ($urandom_range(maxgap, 0)) begin @(posedge clk); #1; end
        strm.in_data = b;
        strm.in_valid = 1'b1;
        start = st;
        n = 0;
        while (!strm.in_ready && n < 100) begin @(posedge clk); #1; n++; end
        chk("ready_timeout", n < 100, 1);
        @(posedge clk); #1;
        strm.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] n, input int maxgap, input bit bad, input bit st_mid);
        logic [7:0]     x;
        logic [31:0]    w;
        logic [AW+31:0] e;
        x = 8'h00;
        wq.delete();
        do_start();
        chk("busy_after_start", busy, 1);
        chk("ready_after_start", strm.in_ready, 1);
        chk("words_cleared", wl, 0);
        send(n[7:0], maxgap, 0);
        send(n[15:8], maxgap, 0);
        for (int i = 0; i < int'(n); i++) begin
            w = pw[i];
            for (int k = 0; k < 4; k++) begin
                x ^= w[8*k +: 8];
                send(w[8*k +: 8], maxgap, st_mid && k == 1);
            end
            chk("we_latency", rom_we, 1);
            chk("we_addr", rom_addr, i);
            chk("we_data", rom_wdata, w);
            chk("words_inc", wl, i + 1);
        end
        send(bad ? (x ^ 8'h01) : x, maxgap, 0);
        chk("done", done, !bad);
        chk("error", err, bad);
        chk("cpu_rst", cpu_rst, bad);
        chk("busy_end", busy, 0);
        chk("ready_end", strm.in_ready, 0);
        chk("words_final", wl, n);
        @(negedge clk);
        chk("we_count", wq.size(), n);
        for (int i = 0; i < int'(n) && i < wq.size(); i++) begin
            e = {AW'(i), pw[i]};
            chk("write", wq[i], e);
        end
    endtask

    initial begin
        strm.in_data = 8'h00;
        strm.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset("reset");
        rst = 1'b0;
        // good two-word program
        pw = '{32'h00a00093, 32'h01400113};
        run_frame(16'd2, 0, 0, 0);
        // same frame, corrupted checksum
        run_frame(16'd2, 0, 1, 0);
        // empty program
        pw.delete();
        run_frame(16'd0, 0, 0, 0);
        // oversize length rejected immediately
        wq.delete();
        do_start();
        send(8'h2C, 0, 0);
        send(8'h01, 0, 0);
        chk("big_error", err, 1);
        chk("big_ready", strm.in_ready, 0);
        chk("big_busy", busy, 0);
        chk("big_cpu_rst", cpu_rst, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("big_no_write", wq.size(), 0);
        // 11 random words with random valid gaps
        pw.delete();
        for (int i = 0; i < 11; i++) pw.push_back($urandom);
        run_frame(16'd11, 5, 0, 0);
        // reset in the middle of a load
        pw = '{32'h00a00093, 32'h01400113};
        do_start();
        send(8'h02, 0, 0);
        send(8'h00, 0, 0);
        send(8'h93, 0, 0);
        send(8'h00, 0, 0);
        send(8'ha0, 0, 0);
        send(8'h00, 0, 0);
        send(8'h13, 0, 0);
        send(8'h01, 0, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset("midrst");
        rst = 1'b0;
        run_frame(16'd2, 0, 0, 0);
        // start pulses during payload are ignored
        pw.delete();
        for (int i = 0; i < 3; i++) pw.push_back($urandom);
        run_frame(16'd3, 2, 0, 1);
        // leaving DONE re-asserts CPU reset and clears status
        do_start();
        chk("redo_cpu_rst", cpu_rst, 1);
        chk("redo_words", wl, 0);
        chk("redo_busy", busy, 1);
        chk("redo_done", done, 0);
        chk("redo_ready", strm.in_ready, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/rom_loader.md
# rom_loader

Boot-time program loader upstream of the multi-cycle RV32I core. Receives a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. Writes each word into the instruction ROM's write port and holds the CPU in reset until a complete load passes its checksum. This replaces hierarchical ROM preloading with a real load path.

## Interface
- ADDR_WIDTH, 8, ROM word-address width; capacity 2^ADDR_WIDTH words
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to begin a load; ignored while busy
- in_data  in  8  stream byte
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte; transfer = in_valid && in_ready
- rom_we  out  1  one-cycle ROM write strobe
- rom_addr  out  ADDR_WIDTH  ROM word address
- rom_wdata  out  32  ROM write data
- cpu_rst  out  1  reset to the CPU core; high unless a load has completed successfully
- busy  out  1  load in progress
- done  out  1  last load succeeded
- error  out  1  last load failed
- words_loaded  out  ADDR_WIDTH+1  count of words written in the current/last load

## Operation
- Frame: LEN_LO, LEN_HI (16-bit word count N), then 4·N payload bytes (LSB first per word), then CSUM byte. CSUM is the XOR of the payload bytes only.
- States:
  - IDLE: start -> LEN0.
  - LEN0: byte -> LEN1.
  - LEN1: byte -> N > 2^ADDR_WIDTH ? ERROR : (N == 0 ? CSUM : DATA).
  - DATA: bytes accumulate; after word N-1's 4th byte -> CSUM.
  - CSUM: byte -> (byte == running XOR) ? DONE : ERROR.
  - DONE/ERROR: start -> LEN0.
- in_ready = 1 exactly in LEN0, LEN1, DATA, CSUM; no other backpressure source. The ROM write happens in parallel with accepting the next byte.
- Byte lane counter 0..3 selects the placement: byte k goes to bits [8k+7:8k]. The counter wraps to 0 after lane 3.
- On the 4th byte of word i: the next cycle has rom_we=1, rom_addr=i, rom_wdata=assembled word, and words_loaded increments to i+1.
- Word index wraps never; N is bounded by the LEN1 check, so the index stops at N-1 ≤ 2^ADDR_WIDTH−1.
- The running XOR and lane/word counters clear on entry to LEN0.
- busy=1 in LEN0..CSUM. done=1 only in DONE. error=1 only in ERROR.
- cpu_rst=0 only in DONE. Leaving DONE via start raises cpu_rst the next cycle.
- start while busy: no effect. start in IDLE/DONE/ERROR clears done/error and words_loaded.
- ROM contents are never cleared by the loader. A failed or aborted load leaves partial words in ROM; the CPU still stays in reset.

## Timing
- Reset values: in_ready 0, rom_we 0, rom_addr 0, rom_wdata 0, cpu_rst 1, busy 0, done 0, error 0, words_loaded 0; state IDLE.
- rst asserted mid-load: next cycle all outputs are at reset values and any pending rom_we is dropped.
- start accepted at edge t: state LEN0 and in_ready=1 from t+1.
- Payload byte latency: 4th byte accepted at edge t -> rom_we high during t+1 only.
- CSUM accepted at edge t -> done or error, and cpu_rst low (on success), from t+1. A CSUM byte accepted in the same cycle as the last word's write is legal.
- in_valid gaps of any length: state holds, no spurious rom_we.
- N > capacity: ERROR one cycle after LEN_HI; no payload byte is accepted.

## Test plan
- Load N=2 with words 0x00a00093, 0x01400113 (bytes 02 00 93 00 a0 00 13 01 40 01 60) -> rom_we at addr 0 then 1 with those words; done=1, cpu_rst=0, words_loaded=2.
- Same frame with CSUM 0x61 -> error=1, cpu_rst=1, ROM addr 0/1 still written, done=0.
- N=0 (bytes 00 00 00) -> no rom_we, done=1, cpu_rst=0. N=300 (2C 01) with ADDR_WIDTH=8 -> error one cycle after LEN_HI, in_ready=0.
- 11-word program streamed with random in_valid gaps (0–5 idle cycles) -> exactly 11 rom_we pulses, addrs 0..10, words match, done=1.
- rst asserted after 6 payload bytes -> all outputs at reset values next cycle. A fresh start plus the full N=2 frame then succeeds.
- start pulses during DATA ignored. start in DONE -> cpu_rst=1 the next cycle, words_loaded=0, busy=1.
